// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, opcodes and decoded-control struct
package cpu_pkg;

    localparam int WIDTH_I    = 32;
    localparam int ADDR_RFILE = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    typedef struct packed {
        logic wr_en;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic uses_rs;
        logic uses_rt;
        logic zext;
    } ctrl_t;

endpackage

// File: rtl/id_decode.sv
// rtl/id_decode.sv - combinational MIPS-subset decoder: control, register fields, sign-extended immediate
module id_decode
    import cpu_pkg::*;
(
    input  logic [WIDTH_I-1:0]    i_instr,
    output ctrl_t                 o_ctrl,
    output logic [ADDR_RFILE-1:0] o_rs,
    output logic [ADDR_RFILE-1:0] o_rt,
    output logic [ADDR_RFILE-1:0] o_rd,
    output logic [WIDTH_I-1:0]    o_imm
);

    logic [5:0] w_op;

    assign w_op  = i_instr[31:26];
    assign o_rs  = i_instr[25:21];
    assign o_rt  = i_instr[20:16];
    // zext is applied by the consumer; this is always the sign-extended field
    assign o_imm = {{(WIDTH_I-16){i_instr[15]}}, i_instr[15:0]};

    always_comb begin
        o_ctrl = '0;
        o_rd   = (w_op == OP_RTYPE) ? i_instr[15:11] : i_instr[20:16];
        case (w_op)
            OP_RTYPE: begin
                o_ctrl.wr_en   = 1'b1;
                o_ctrl.uses_rs = 1'b1;
                o_ctrl.uses_rt = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.wr_en   = 1'b1;
                o_ctrl.uses_rs = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                o_ctrl.wr_en   = 1'b1;
                o_ctrl.uses_rs = 1'b1;
                o_ctrl.zext    = 1'b1;
            end
            OP_LW: begin
                o_ctrl.wr_en   = 1'b1;
                o_ctrl.is_load = 1'b1;
                o_ctrl.uses_rs = 1'b1;
            end
            OP_SW: begin
                o_ctrl.is_store = 1'b1;
                o_ctrl.uses_rs  = 1'b1;
                o_ctrl.uses_rt  = 1'b1;
            end
            OP_BEQ: begin
                o_ctrl.is_branch = 1'b1;
                o_ctrl.uses_rs   = 1'b1;
                o_ctrl.uses_rt   = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
        if (o_rd == '0) begin
            o_ctrl.wr_en = 1'b0;
        end
    end

endmodule

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - ID stage: operand forwarding, load-use/EX hazard stall, ID/EX register
module id_operand_stage
    import cpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid,
    input  logic [WIDTH_I-1:0]    if_instr,
    input  logic [WIDTH_I-1:0]    if_pc,
    input  logic                  flush,
    output logic                  id_stall,
    output logic [ADDR_RFILE-1:0] ra_addr,
    output logic [ADDR_RFILE-1:0] rb_addr,
    input  logic [WIDTH_I-1:0]    ra_data,
    input  logic [WIDTH_I-1:0]    rb_data,
    input  logic                  ex_wr_en,
    input  logic [ADDR_RFILE-1:0] ex_wr_addr,
    input  logic                  mem_wr_en,
    input  logic [ADDR_RFILE-1:0] mem_wr_addr,
    input  logic                  mem_is_load,
    input  logic [WIDTH_I-1:0]    mem_wr_data,
    input  logic                  wb_wr_en,
    input  logic [ADDR_RFILE-1:0] wb_wr_addr,
    input  logic [WIDTH_I-1:0]    wb_wr_data,
    output logic                  idex_valid,
    output logic                  idex_wr_en,
    output logic                  idex_is_load,
    output logic                  idex_is_store,
    output logic                  idex_is_branch,
    output logic [WIDTH_I-1:0]    idex_pc,
    output logic [WIDTH_I-1:0]    idex_opa,
    output logic [WIDTH_I-1:0]    idex_opb,
    output logic [WIDTH_I-1:0]    idex_imm,
    output logic [ADDR_RFILE-1:0] idex_rd,
    output logic [5:0]            idex_opcode,
    output logic [5:0]            idex_funct,
    output logic [15:0]           stall_cnt
);

    ctrl_t                 w_ctrl;
    logic [ADDR_RFILE-1:0] w_rs;
    logic [ADDR_RFILE-1:0] w_rt;
    logic [ADDR_RFILE-1:0] w_rd;
    logic [WIDTH_I-1:0]    w_imm_sext;
    logic [WIDTH_I-1:0]    w_imm;
    logic [WIDTH_I-1:0]    w_opa;
    logic [WIDTH_I-1:0]    w_opb;
    logic                  w_haz_rs;
    logic                  w_haz_rt;
    logic                  w_issue;

    logic                  r_valid;
    logic                  r_wr_en;
    logic                  r_is_load;
    logic                  r_is_store;
    logic                  r_is_branch;
    logic [WIDTH_I-1:0]    r_pc;
    logic [WIDTH_I-1:0]    r_opa;
    logic [WIDTH_I-1:0]    r_opb;
    logic [WIDTH_I-1:0]    r_imm;
    logic [ADDR_RFILE-1:0] r_rd;
    logic [5:0]            r_opcode;
    logic [5:0]            r_funct;
    logic [15:0]           r_stall_cnt;

    id_decode u_decode (
        .i_instr (if_instr),
        .o_ctrl  (w_ctrl),
        .o_rs    (w_rs),
        .o_rt    (w_rt),
        .o_rd    (w_rd),
        .o_imm   (w_imm_sext)
    );

    assign ra_addr = w_rs;
    assign rb_addr = w_rt;
    assign w_imm   = w_ctrl.zext ? {{(WIDTH_I-16){1'b0}}, w_imm_sext[15:0]} : w_imm_sext;

    // A MEM-stage load has no data yet, so only non-load MEM results are forwarded
    assign w_opa = (w_rs == '0) ? '0 :
                   (mem_wr_en && !mem_is_load && mem_wr_addr == w_rs) ? mem_wr_data :
                   (wb_wr_en && wb_wr_addr == w_rs) ? wb_wr_data : ra_data;
    assign w_opb = (w_rt == '0) ? '0 :
                   (mem_wr_en && !mem_is_load && mem_wr_addr == w_rt) ? mem_wr_data :
                   (wb_wr_en && wb_wr_addr == w_rt) ? wb_wr_data : rb_data;

    assign w_haz_rs = w_ctrl.uses_rs && (w_rs != '0) &&
                      ((ex_wr_en && ex_wr_addr == w_rs) ||
                       (mem_wr_en && mem_is_load && mem_wr_addr == w_rs));
    assign w_haz_rt = w_ctrl.uses_rt && (w_rt != '0) &&
                      ((ex_wr_en && ex_wr_addr == w_rt) ||
                       (mem_wr_en && mem_is_load && mem_wr_addr == w_rt));

    assign id_stall = if_valid && !flush && (w_haz_rs || w_haz_rt);
    assign w_issue  = if_valid && !flush && !id_stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_is_branch <= 1'b0;
            r_pc        <= '0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_opcode    <= '0;
            r_funct     <= '0;
            r_stall_cnt <= '0;
        end else begin
            // Bubbles still capture decoded data fields so they stay deterministic
            r_valid     <= w_issue;
            r_wr_en     <= w_issue && w_ctrl.wr_en;
            r_is_load   <= w_issue && w_ctrl.is_load;
            r_is_store  <= w_issue && w_ctrl.is_store;
            r_is_branch <= w_issue && w_ctrl.is_branch;
            r_pc        <= if_pc;
            r_opa       <= w_opa;
            r_opb       <= w_opb;
            r_imm       <= w_imm;
            r_rd        <= w_rd;
            r_opcode    <= if_instr[31:26];
            r_funct     <= if_instr[5:0];
            if (id_stall && r_stall_cnt != 16'hFFFF) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign idex_valid     = r_valid;
    assign idex_wr_en     = r_wr_en;
    assign idex_is_load   = r_is_load;
    assign idex_is_store  = r_is_store;
    assign idex_is_branch = r_is_branch;
    assign idex_pc        = r_pc;
    assign idex_opa       = r_opa;
    assign idex_opb       = r_opb;
    assign idex_imm       = r_imm;
    assign idex_rd        = r_rd;
    assign idex_opcode    = r_opcode;
    assign idex_funct     = r_funct;
    assign stall_cnt      = r_stall_cnt;

endmodule
